// File: rtl/timersoc_pio_pkg.sv
// Shared constants for the TimerSoC input PIO: register word addresses,
// edge-select encodings and a constant-foldable ceil(log2) helper.
package timersoc_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Smallest r with 2**r >= v; 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/timersoc_debounce.sv
// One-channel debounce filter: filt follows sync2 only after sync2 has
// differed from filt for DEBOUNCE_CYCLES consecutive clocks.
module timersoc_debounce
    import timersoc_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sync2,
    output logic filt
);

    localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timersoc_buttons_irq.sv
// Avalon-MM input PIO with synchroniser, edge capture, irq mask and irq.
// Define TIMERSOC_BUTTONS_DEBOUNCE_EN to insert a per-channel debounce filter.
module timersoc_buttons_irq
    import timersoc_pio_pkg::*;
#(
    parameter int               WIDTH           = 2,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] IRQ_MASK_RESET  = '0,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1, sync2, level, prev;
    logic [WIDTH-1:0] rise, fall, edges;
    logic [WIDTH-1:0] edge_capture, irq_mask, clear;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_wdata;

`ifdef TIMERSOC_BUTTONS_DEBOUNCE_EN
    logic [WIDTH-1:0] filt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        timersoc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .sync2 (sync2[i]),
            .filt  (filt[i])
        );
    end

    assign level = filt;
`else
    assign level = sync2;

    // Filter length has no effect in this build.
    if (DEBOUNCE_CYCLES < 2) begin : g_db_ignored
    end
`endif

    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
    assign edges = (EDGE_TYPE == EDGE_RISING)  ? rise :
                   (EDGE_TYPE == EDGE_FALLING) ? fall : (rise | fall);

    assign wr    = chipselect & ~write_n;
    assign clear = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign irq   = |(edge_capture & irq_mask);

    // Upper write-data bits have no destination register.
    assign unused_wdata = ^writedata;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = level;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
            default:   rd_mux = '0;
        endcase
    end

    // A new edge on a bit wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            prev         <= '0;
            edge_capture <= '0;
            irq_mask     <= IRQ_MASK_RESET;
            readdata     <= '0;
        end else begin
            sync1        <= in_port;
            sync2        <= sync1;
            prev         <= level;
            edge_capture <= edges | (edge_capture & ~clear);
            if (wr && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
            readdata     <= rd_mux;
        end
    end

endmodule

// File: tb/tb_timersoc_buttons_irq.sv
// Directed bench for timersoc_buttons_irq: a rising-edge instance driven from
// a vector table, plus an any-edge instance for the pulse sequence.
module tb_timersoc_buttons_irq;

`ifdef TIMERSOC_BUTTONS_DEBOUNCE_EN
    localparam int L = 7;
`else
    localparam int L = 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [1:0]  in_a = 2'b00;
    logic [1:0]  in_b = 2'b00;
    logic [31:0] readdata_a, readdata_b;
    logic        irq_a, irq_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timersoc_buttons_irq #(
        .WIDTH(2), .EDGE_TYPE(0), .IRQ_MASK_RESET(2'b00), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(readdata_a), .irq(irq_a)
    );

    timersoc_buttons_irq #(
        .WIDTH(2), .EDGE_TYPE(2), .IRQ_MASK_RESET(2'b00), .DEBOUNCE_CYCLES(4)
    ) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    typedef struct {
        logic [1:0]  in_v;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //         in     wr    addr  wdata  hold   rd     irq
        vt[0]  = '{2'b00, 1'b0, 2'd0, 32'd0, 1,     32'd0, 1'b0};
        vt[1]  = '{2'b00, 1'b0, 2'd2, 32'd0, 1,     32'd0, 1'b0};
        vt[2]  = '{2'b00, 1'b0, 2'd3, 32'd0, 1,     32'd0, 1'b0};
        vt[3]  = '{2'b00, 1'b1, 2'd2, 32'd1, 1,     32'd0, 1'b0};
        vt[4]  = '{2'b00, 1'b0, 2'd2, 32'd0, 1,     32'd1, 1'b0};
        vt[5]  = '{2'b01, 1'b0, 2'd3, 32'd0, L - 1, 32'd0, 1'b0};
        vt[6]  = '{2'b01, 1'b0, 2'd3, 32'd0, 1,     32'd0, 1'b1};
        vt[7]  = '{2'b01, 1'b0, 2'd3, 32'd0, 1,     32'd1, 1'b1};
        vt[8]  = '{2'b01, 1'b0, 2'd0, 32'd0, 1,     32'd1, 1'b1};
        vt[9]  = '{2'b01, 1'b1, 2'd3, 32'd1, 1,     32'd1, 1'b0};
        vt[10] = '{2'b01, 1'b0, 2'd3, 32'd0, 1,     32'd0, 1'b0};
        vt[11] = '{2'b11, 1'b0, 2'd3, 32'd0, L,     32'd0, 1'b0};
        vt[12] = '{2'b11, 1'b0, 2'd3, 32'd0, 1,     32'd2, 1'b0};
        vt[13] = '{2'b11, 1'b1, 2'd2, 32'd3, 1,     32'd1, 1'b1};
        vt[14] = '{2'b11, 1'b0, 2'd0, 32'd0, 1,     32'd3, 1'b1};
        vt[15] = '{2'b11, 1'b1, 2'd3, 32'd3, 1,     32'd2, 1'b0};
        vt[16] = '{2'b10, 1'b0, 2'd3, 32'd0, L,     32'd0, 1'b0};
        vt[17] = '{2'b10, 1'b0, 2'd0, 32'd0, 1,     32'd2, 1'b0};
        vt[18] = '{2'b11, 1'b0, 2'd3, 32'd0, L - 1, 32'd0, 1'b0};
        vt[19] = '{2'b11, 1'b1, 2'd3, 32'd1, 1,     32'd0, 1'b1};
        vt[20] = '{2'b11, 1'b0, 2'd3, 32'd0, 1,     32'd1, 1'b1};
        vt[21] = '{2'b11, 1'b0, 2'd0, 32'd0, 1,     32'd3, 1'b1};

        reset = 1'b1;
        tick();
        tick();
        chk("reset irq", 32'(irq_a), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            in_a       = vt[i].in_v;
            address    = vt[i].addr;
            writedata  = vt[i].wdata;
            chipselect = vt[i].wr;
            write_n    = ~vt[i].wr;
            for (int h = 0; h < vt[i].hold; h++) begin
                tick();
                chipselect = 1'b0;
                write_n    = 1'b1;
            end
            chk($sformatf("vec%0d readdata", i), readdata_a, vt[i].exp_rd);
            chk($sformatf("vec%0d irq", i), 32'(irq_a), 32'(vt[i].exp_irq));
        end

        // Asynchronous reset mid-operation, input held high through release.
        in_a  = 2'b01;
        reset = 1'b1;
        #1;
        chk("async reset irq", 32'(irq_a), 32'd0);
        chk("async reset readdata", readdata_a, 32'd0);
        tick();
        reset   = 1'b0;
        address = 2'd3;
        for (int h = 0; h < L; h++) tick();
        chk("held-high capture pending", readdata_a, 32'd0);
        tick();
        chk("held-high capture", readdata_a, 32'd1);
        address = 2'd2;
        tick();
        chk("mask after reset", readdata_a, 32'd0);

        // Any-edge instance: a 5-cycle pulse yields rise and fall captures.
        in_a = 2'b00;
        in_b = 2'b00;
        do_reset();
        bus_write(2'd2, 32'd1);
        for (int k = 1; k <= 5 + L; k++) begin
            in_b = (k <= 5) ? 2'b01 : 2'b00;
            if (k == L + 1) begin
                address    = 2'd3;
                writedata  = 32'd1;
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
            tick();
            chipselect = 1'b0;
            write_n    = 1'b1;
            if (k == L)         chk("any rise irq", 32'(irq_b), 32'd1);
            if (k == L + 1)     chk("any cleared irq", 32'(irq_b), 32'd0);
            if (k == 5 + L - 1) chk("any before fall irq", 32'(irq_b), 32'd0);
            if (k == 5 + L)     chk("any fall irq", 32'(irq_b), 32'd1);
        end
        address = 2'd3;
        tick();
        chk("any fall capture", readdata_b, 32'd1);

`ifdef TIMERSOC_BUTTONS_DEBOUNCE_EN
        // Bounce shorter than the filter length must not reach the capture.
        do_reset();
        bus_write(2'd2, 32'd1);
        address = 2'd3;
        in_a = 2'b01; tick();
        in_a = 2'b00; tick();
        in_a = 2'b01; tick();
        in_a = 2'b00;
        for (int h = 0; h < 12; h++) tick();
        chk("bounce no capture", readdata_a, 32'd0);
        chk("bounce no irq", 32'(irq_a), 32'd0);
        address = 2'd0;
        tick();
        chk("bounce level", readdata_a, 32'd0);

        in_a = 2'b01;
        for (int h = 0; h < L - 1; h++) tick();
        chk("hold before filt irq", 32'(irq_a), 32'd0);
        tick();
        chk("hold filt irq", 32'(irq_a), 32'd1);
        chk("hold filt level", readdata_a, 32'd1);
        bus_write(2'd3, 32'd1);
        for (int h = 0; h < 10; h++) tick();
        chk("captured once", 32'(irq_a), 32'd0);

        in_a = 2'b00;
        for (int h = 0; h < 10; h++) tick();
        in_a = 2'b01;
        for (int h = 0; h < 4; h++) tick();
        reset = 1'b1;
        #1;
        chk("reset during hold irq", 32'(irq_a), 32'd0);
        chk("reset during hold readdata", readdata_a, 32'd0);
        tick();
        reset   = 1'b0;
        address = 2'd0;
        tick();
        chk("reset during hold level", readdata_a, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
